// File: rtl/mux_arb_if.sv
// Handshake bundle between the producers, mux_arb and its single consumer.
// slave is the mux side; master is the producer/consumer environment side.
interface mux_arb_if #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4
);
  localparam int SW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SW-1:0]             out_sel;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_arb.sv
// Registered CHANNELS-to-1 mux with valid/ready handshaking and automatic arbitration.
// Define MUX_ROUND_ROBIN_EN for round-robin grants; otherwise the lowest valid index wins.
module mux_arb #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4
) (
  input  logic     clk,
  input  logic     rst,
  mux_arb_if.slave bus
);
  localparam int SW = $clog2(CHANNELS);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                load;
  logic                grantValid;
  logic [SW-1:0]       grantIdx;
  logic [CHANNELS-1:0] readyVec;
  logic [WIDTH-1:0]    words [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_words
    assign words[c] = bus.in_data[c*WIDTH +: WIDTH];
  end

  assign load = (state_q == EMPTY) || bus.out_ready;

`ifdef MUX_ROUND_ROBIN_EN
  logic [SW-1:0] last_q, last_d;
  logic          upValid;
  logic [SW-1:0] upIdx;
  logic [SW-1:0] lowIdx;

  // Prefer the lowest requester above the last winner; otherwise wrap to the lowest requester overall.
  always_comb begin
    upValid    = 1'b0;
    upIdx      = '0;
    lowIdx     = '0;
    grantValid = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (bus.in_valid[c]) begin
        grantValid = 1'b1;
        lowIdx     = SW'(c);
        if (SW'(c) > last_q) begin
          upValid = 1'b1;
          upIdx   = SW'(c);
        end
      end
    end
    grantIdx = upValid ? upIdx : lowIdx;
  end

  always_comb begin
    last_d = last_q;
    if (load && grantValid) begin
      last_d = grantIdx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SW'(CHANNELS - 1);
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (bus.in_valid[c]) begin
        grantValid = 1'b1;
        grantIdx   = SW'(c);
      end
    end
  end
`endif

  // A drain and a refill share one edge, so a FULL register with out_ready high never bubbles.
  always_comb begin
    readyVec = '0;
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    if (load) begin
      if (grantValid) begin
        readyVec[grantIdx] = 1'b1;
        state_d            = FULL;
        data_d             = words[grantIdx];
        sel_d              = grantIdx;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.in_ready  = readyVec;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: random producers and consumer; expected words queued from a channel-level
// model and checked by an independent output monitor.
module tb_mux_arb;
  localparam int WIDTH    = 3;
  localparam int CHANNELS = 4;
  localparam int SW       = $clog2(CHANNELS);

  logic clk = 1'b0;
  logic rst;

  mux_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  mux_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int sel;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  bit   pend [CHANNELS];
  int   word [CHANNELS];
  int   modelLast   = CHANNELS - 1;
  int   holdData    = 0;
  int   holdSel     = 0;
  int   xferCh      = -1;
  bit   monOn       = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pickChannel(input bit [CHANNELS-1:0] v, input int last);
`ifdef MUX_ROUND_ROBIN_EN
    for (int k = 1; k <= CHANNELS; k++) begin
      if (v[(last + k) % CHANNELS]) return (last + k) % CHANNELS;
    end
`else
    for (int c = 0; c < CHANNELS; c++) begin
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  // Producers keep an unsent word until it is granted; idle ones may pick up a new word.
  task automatic applyStimulus(input int validPct, input int readyPct);
    if (xferCh >= 0) pend[xferCh] = 1'b0;
    xferCh = -1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!pend[c] && ($urandom_range(99) < validPct)) begin
        pend[c] = 1'b1;
        word[c] = $urandom_range((1 << WIDTH) - 1);
      end
      bus.in_valid[c]                = pend[c];
      bus.in_data[c*WIDTH +: WIDTH] = WIDTH'(word[c]);
    end
    bus.out_ready = ($urandom_range(99) < readyPct);
  endtask

  task automatic modelStep();
    bit [CHANNELS-1:0] v;
    bit [CHANNELS-1:0] expReady;
    int g;
    for (int c = 0; c < CHANNELS; c++) v[c] = pend[c];
    expReady = '0;
    g = pickChannel(v, modelLast);
    if ((expQ.size() == 0) && (g >= 0)) begin
      expReady[g] = 1'b1;
      expQ.push_back('{word[g], g});
      modelLast = g;
      holdData  = word[g];
      holdSel   = g;
      xferCh    = g;
    end
    checkOutput("in_ready", int'(bus.in_ready), int'(expReady));
  endtask

  task automatic runCycles(input int n, input int validPct, input int readyPct);
    repeat (n) begin
      @(posedge clk);
      #1;
      applyStimulus(validPct, readyPct);
      @(negedge clk);
      #1;
      modelStep();
    end
  endtask

  task automatic asyncReset();
    @(posedge clk);
    #1;
    applyStimulus(0, 0);
    checkOutput("pre_reset_full", int'(bus.out_valid), int'(expQ.size() != 0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", int'(bus.out_valid), 0);
    checkOutput("async_rst_data", int'(bus.out_data), 0);
    checkOutput("async_rst_sel", int'(bus.out_sel), 0);
    expQ.delete();
    holdData  = 0;
    holdSel   = 0;
    modelLast = CHANNELS - 1;
    xferCh    = -1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    modelStep();
  endtask

  always @(negedge clk) begin
    if (monOn && !rst) begin
      checkOutput("out_valid", int'(bus.out_valid), int'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("out_data", int'(bus.out_data), expQ[0].data);
        checkOutput("out_sel", int'(bus.out_sel), expQ[0].sel);
        if (bus.out_ready) void'(expQ.pop_front());
      end else begin
        checkOutput("hold_data", int'(bus.out_data), holdData);
        checkOutput("hold_sel", int'(bus.out_sel), holdSel);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      pend[c] = 1'b0;
      word[c] = 0;
    end
    #2;
    checkOutput("reset_valid", int'(bus.out_valid), 0);
    checkOutput("reset_data", int'(bus.out_data), 0);
    checkOutput("reset_sel", int'(bus.out_sel), 0);
    checkOutput("reset_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    #1;
    rst   = 1'b0;
    monOn = 1'b1;
    #1;
    modelStep();

    runCycles(300, 50, 70);
    runCycles(6, 100, 0);
    asyncReset();
    runCycles(40, 100, 100);
    runCycles(20, 0, 100);
    runCycles(300, 30, 50);
    runCycles(6, 100, 0);
    asyncReset();
    runCycles(300, 80, 90);
    runCycles(10, 0, 100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised, registered N-to-1 multiplexer with valid/ready handshaking on every channel and an arbiter that picks the next input automatically. It generalises our 3-bit 2:1 select mux to CHANNELS inputs of WIDTH bits each. It sits between several producer blocks and a single consumer and delivers one word per cycle at full throughput with back-pressure.

## Interface
- WIDTH, 3: data width of each channel, at least 1.
- CHANNELS, 4: number of input channels, at least 2.
- SW, $clog2(CHANNELS): width of the channel index (localparam).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  channel i has a word to send.
- in_ready  output  CHANNELS  channel i's word is taken this cycle; one-hot or zero.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  out_data holds a word for the consumer.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  SW  index of the channel that supplied out_data.

## Operation
- There are two states, held by out_valid: EMPTY (out_valid=0) and FULL (out_valid=1).
- `load` = !out_valid || out_ready. The output register can take a new word this cycle.
- Grant selection (combinational):
  - The arbiter picks one channel among those with in_valid=1, using the scheme set under Configuration.
  - If no channel is valid, there is no grant.
- in_ready[g] = load && grant[g]. Every other bit of in_ready is 0.
- A transfer from channel g occurs when in_valid[g] && in_ready[g].
- When load=1 on a clock edge:
  - With a grant: out_data <= word of channel g, out_sel <= g, out_valid <= 1, and the round-robin pointer `last` <= g.
  - With no grant: out_valid <= 0. out_data and out_sel keep their values.
- When load=0 (FULL and out_ready=0): out_data, out_sel and out_valid stay stable. No in_ready is asserted.
- Simultaneous drain and load: when FULL, out_ready=1 and some channel is valid, the register is refilled on the same edge. One word passes per cycle with no bubble.
- in_ready depends combinationally on in_valid and out_ready. A producer must not make in_valid depend on in_ready.
- A producer holds in_valid and in_data until it sees in_ready. A channel that is not granted keeps its request and loses no data.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, in_ready=0 (in_ready follows from the reset state and idle inputs).
  - `last`=CHANNELS-1, so channel 0 has first priority.
- Reset mid-operation: a word held in the output register is discarded. Producers re-present their words after reset.

## Timing
- Latency from an input transfer to out_valid with that word is 1 clock edge.
- Throughput is 1 word per cycle while out_ready=1 and at least one channel is valid.
- The output and `last` are the only registers. in_ready is combinational within the cycle.
- rst takes effect immediately, without waiting for clk. Release of rst must be synchronous to clk at system level.

## Configuration
- MUX_ROUND_ROBIN_EN defined:
  - The arbiter searches from (last+1) mod CHANNELS upward, wrapping around, and grants the first valid channel.
  - While every channel stays valid, a channel waits at most CHANNELS-1 grants.
- MUX_ROUND_ROBIN_EN not defined:
  - Fixed priority: the lowest valid index always wins.
  - The `last` register is not built. out_sel still reports the granted channel.

## Test plan
- Reset with rst=1 mid-stream (FULL, out_data=5) -> out_valid=0, out_data=0, out_sel=0 immediately without a clock edge.
- Single channel, in_valid=4'b0100, in_data channel 2 = 3'd6, out_ready=1:
  - in_ready=4'b0100.
  - On the next cycle out_valid=1, out_data=6, out_sel=2.
  - When in_valid drops, out_valid=0 one cycle later.
- All four channels valid with data 1, 2, 3, 4 and out_ready=1, MUX_ROUND_ROBIN_EN defined -> out_sel sequence 0,1,2,3,0, out_data 1,2,3,4,1. Without the macro -> out_sel stays 0 every cycle.
- Back-pressure, FULL with out_data=3, out_ready=0 for 3 cycles while channels 1 and 3 are valid:
  - in_ready=0 and out_data=3 for all 3 cycles.
  - On the cycle out_ready=1, one channel is granted and the refill takes effect on the same edge.
- Wrap-around: last=3 and in_valid=4'b1001 -> grant channel 0. Then last=0, and with in_valid=4'b1001 still set -> grant channel 3.
- Idle drain: FULL, out_ready=1, in_valid=0 -> out_valid falls on the next edge, and out_data and out_sel hold their last values.
